// File: rtl/adpll_ctrl_pkg.sv
// Shared types and constants for the ADPLL acquisition / lock-supervision controller.
// Holds the state encoding, gain selections, port widths and DCO rail codes.
package adpll_ctrl_pkg;

  localparam int ERR_W = 8;
  localparam int DCO_W = 9;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_RESET_PLL = 3'd1,
    ST_SETTLE    = 3'd2,
    ST_COARSE    = 3'd3,
    ST_FINE      = 3'd4,
    ST_LOCKED    = 3'd5,
    ST_FAILED    = 3'd6
  } state_t;

  localparam logic [1:0] GAIN_OFF    = 2'b00;
  localparam logic [1:0] GAIN_COARSE = 2'b10;
  localparam logic [1:0] GAIN_FINE   = 2'b01;

  // Two's-complement extremes of the 9-bit DCO code (+255 / -256).
  localparam logic [DCO_W-1:0] DCO_RAIL_HI = 9'h0FF;
  localparam logic [DCO_W-1:0] DCO_RAIL_LO = 9'h100;

  // Unsigned magnitude; -128 wraps to 8'h80, which reads as 128 unsigned.
  function automatic logic [ERR_W-1:0] err_mag(input logic [ERR_W-1:0] e);
    return e[ERR_W-1] ? (~e + ERR_W'(1)) : e;
  endfunction

  function automatic logic dco_is_rail(input logic [DCO_W-1:0] d);
    return (d == DCO_RAIL_HI) || (d == DCO_RAIL_LO);
  endfunction

  function automatic logic [1:0] gain_for(input state_t s);
    case (s)
      ST_SETTLE, ST_COARSE: return GAIN_COARSE;
      ST_FINE, ST_LOCKED:   return GAIN_FINE;
      default:              return GAIN_OFF;
    endcase
  endfunction

endpackage

// File: rtl/ref_edge_sync.sv
// Brings the asynchronous reference clock into the system domain and emits a
// one-cycle tick per reference rising edge (2 sync flops, history flop, registered tick).
module ref_edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic ref_clk,
  output logic tick
);

  // sync_reg[0..1] are the metastability stages, sync_reg[2] the previous sample.
  logic [2:0] sync_reg;
  logic       tick_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_reg <= 3'b000;
      tick_reg <= 1'b0;
    end else begin
      sync_reg <= {sync_reg[1:0], ref_clk};
      tick_reg <= sync_reg[1] & ~sync_reg[2];
    end
  end

  assign tick = tick_reg;

endmodule

// File: rtl/adpll_lock_ctrl.sv
// Acquisition and lock-supervision controller for the ring ADPLL.
// Optional feature: define ADPLL_DCO_RAIL_CHECK_EN to abort attempts whose DCO code sits on a rail.
module adpll_lock_ctrl
  import adpll_ctrl_pkg::*;
#(
  parameter int RST_CYCLES    = 8,
  parameter int SETTLE_REFS   = 32,
  parameter int COARSE_THRESH = 16,
  parameter int COARSE_COUNT  = 8,
  parameter int LOCK_THRESH   = 4,
  parameter int LOCK_COUNT    = 16,
  parameter int UNLOCK_THRESH = 16,
  parameter int UNLOCK_COUNT  = 4,
  parameter int TIMEOUT_REFS  = 1024,
  parameter int MAX_RETRY     = 3
) (
  input  logic             fpga_clk_i,
  input  logic             reset_n_i,
  input  logic             ref_clk_i,
  input  logic             start_i,
  input  logic [ERR_W-1:0] error_i,
  input  logic [DCO_W-1:0] dco_cc_i,
  output logic             pll_reset_o,
  output logic             pll_enable_o,
  output logic [1:0]       gain_sel_o,
  output logic             locked_o,
  output logic             loss_o,
  output logic             fail_o,
  output logic             rail_o,
  output logic [1:0]       retry_count_o,
  output logic [2:0]       state_o
);

  localparam int MAX_A   = (TIMEOUT_REFS > SETTLE_REFS) ? TIMEOUT_REFS : SETTLE_REFS;
  localparam int MAX_B   = (RST_CYCLES > LOCK_COUNT) ? RST_CYCLES : LOCK_COUNT;
  localparam int CNT_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  logic tick;

  ref_edge_sync u_ref_sync (
    .clk     (fpga_clk_i),
    .rst_n   (reset_n_i),
    .ref_clk (ref_clk_i),
    .tick    (tick)
  );

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [CNT_W-1:0] to_reg, to_next;
  logic [CNT_W-1:0] to_inc;
  logic [1:0]       retry_reg, retry_next;
  logic             loss_next, rail_next;
  logic             abort;
  logic             to_expired;
  logic             rail_hit;
  logic [ERR_W-1:0] mag;

  logic       pll_reset_reg, pll_enable_reg, locked_reg, loss_reg, fail_reg, rail_reg;
  logic [1:0] gain_reg;

  assign mag        = err_mag(error_i);
  assign to_inc     = (&to_reg) ? to_reg : to_reg + CNT_W'(1);
  assign to_expired = (to_inc >= CNT_W'(TIMEOUT_REFS));

`ifdef ADPLL_DCO_RAIL_CHECK_EN
  logic [3:0] rail_cnt_reg, rail_cnt_next;
  logic       rail_watch;

  assign rail_watch = tick && ((state_reg == ST_COARSE) || (state_reg == ST_FINE) ||
                               (state_reg == ST_LOCKED));
  assign rail_hit   = rail_watch && dco_is_rail(dco_cc_i) && (rail_cnt_reg == 4'd7);

  always_comb begin
    rail_cnt_next = rail_cnt_reg;
    if (state_next != state_reg)
      rail_cnt_next = 4'd0;
    else if (rail_watch)
      rail_cnt_next = dco_is_rail(dco_cc_i) ? rail_cnt_reg + 4'd1 : 4'd0;
  end

  always_ff @(posedge fpga_clk_i or negedge reset_n_i) begin
    if (!reset_n_i) rail_cnt_reg <= 4'd0;
    else            rail_cnt_reg <= rail_cnt_next;
  end
`else
  logic unused_dco;
  assign unused_dco = ^dco_cc_i;
  assign rail_hit   = 1'b0;
`endif

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    to_next    = to_reg;
    retry_next = retry_reg;
    loss_next  = 1'b0;
    rail_next  = 1'b0;
    abort      = 1'b0;

    if (!start_i) begin
      state_next = ST_IDLE;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          retry_next = 2'd1;
          state_next = ST_RESET_PLL;
        end
        ST_RESET_PLL: begin
          if (cnt_reg == CNT_W'(RST_CYCLES - 1)) begin
            state_next = ST_SETTLE;
            to_next    = '0;
          end else begin
            cnt_next = cnt_reg + CNT_W'(1);
          end
        end
        ST_SETTLE: begin
          if (tick) begin
            if (cnt_reg == CNT_W'(SETTLE_REFS - 1)) state_next = ST_COARSE;
            else                                    cnt_next   = cnt_reg + CNT_W'(1);
          end
        end
        ST_COARSE: begin
          if (tick) begin
            to_next = to_inc;
            if (mag <= ERR_W'(COARSE_THRESH)) begin
              if (cnt_reg == CNT_W'(COARSE_COUNT - 1)) state_next = ST_FINE;
              else                                     cnt_next   = cnt_reg + CNT_W'(1);
            end else begin
              cnt_next = '0;
            end
            abort = (state_next == ST_COARSE) && (to_expired || rail_hit);
          end
        end
        ST_FINE: begin
          if (tick) begin
            to_next = to_inc;
            if (mag > ERR_W'(COARSE_THRESH)) begin
              state_next = ST_COARSE;
            end else if (mag <= ERR_W'(LOCK_THRESH)) begin
              if (cnt_reg == CNT_W'(LOCK_COUNT - 1)) state_next = ST_LOCKED;
              else                                   cnt_next   = cnt_reg + CNT_W'(1);
            end else begin
              cnt_next = '0;
            end
            abort = (state_next == ST_FINE) && (to_expired || rail_hit);
          end
        end
        ST_LOCKED: begin
          if (tick) begin
            // Loss of lock restarts convergence with a fresh timeout budget, not a retry.
            if (mag > ERR_W'(UNLOCK_THRESH)) begin
              if (cnt_reg == CNT_W'(UNLOCK_COUNT - 1)) begin
                state_next = ST_COARSE;
                loss_next  = 1'b1;
                to_next    = '0;
              end else begin
                cnt_next = cnt_reg + CNT_W'(1);
              end
            end else begin
              cnt_next = '0;
            end
            abort = (state_next == ST_LOCKED) && rail_hit;
          end
        end
        ST_FAILED: ;
        default:   state_next = ST_IDLE;
      endcase

      if (abort) begin
        rail_next = rail_hit;
        if (retry_reg < 2'(MAX_RETRY)) begin
          state_next = ST_RESET_PLL;
          retry_next = (retry_reg == 2'd3) ? 2'd3 : retry_reg + 2'd1;
        end else begin
          state_next = ST_FAILED;
        end
      end
    end

    if (state_next != state_reg) cnt_next = '0;
  end

  // Outputs are registered from the next state so they move together with state_reg.
  always_ff @(posedge fpga_clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_reg      <= ST_IDLE;
      cnt_reg        <= '0;
      to_reg         <= '0;
      retry_reg      <= 2'd0;
      pll_reset_reg  <= 1'b1;
      pll_enable_reg <= 1'b0;
      gain_reg       <= GAIN_OFF;
      locked_reg     <= 1'b0;
      loss_reg       <= 1'b0;
      fail_reg       <= 1'b0;
      rail_reg       <= 1'b0;
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      to_reg         <= to_next;
      retry_reg      <= retry_next;
      pll_reset_reg  <= (state_next == ST_IDLE) || (state_next == ST_RESET_PLL) ||
                        (state_next == ST_FAILED);
      pll_enable_reg <= (state_next == ST_SETTLE) || (state_next == ST_COARSE) ||
                        (state_next == ST_FINE) || (state_next == ST_LOCKED);
      gain_reg       <= gain_for(state_next);
      locked_reg     <= (state_next == ST_LOCKED);
      loss_reg       <= loss_next;
      fail_reg       <= (state_next == ST_FAILED);
      rail_reg       <= rail_next;
    end
  end

  assign pll_reset_o   = pll_reset_reg;
  assign pll_enable_o  = pll_enable_reg;
  assign gain_sel_o    = gain_reg;
  assign locked_o      = locked_reg;
  assign loss_o        = loss_reg;
  assign fail_o        = fail_reg;
  assign rail_o        = rail_reg;
  assign retry_count_o = retry_reg;
  assign state_o       = state_reg;

endmodule

// File: tb/tb_adpll_lock_ctrl.sv
// Self-checking bench for adpll_lock_ctrl: directed table, corner sequences and
// randomized stimulus checked every cycle against a behavioural model.
`timescale 1ns/1ps
module tb_adpll_lock_ctrl;

  localparam int S_IDLE = 0, S_RST = 1, S_SETTLE = 2, S_COARSE = 3;
  localparam int S_FINE = 4, S_LOCKED = 5, S_FAILED = 6;
  localparam int REF_DIV = 6;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ref_clk = 1'b0;
  logic       start = 1'b0;
  logic [7:0] err = 8'd0;
  logic [8:0] dco = 9'd0;

  logic       pll_reset, pll_enable, locked, loss, fail, rail;
  logic [1:0] gain_sel, retry_count;
  logic [2:0] state;

  always #5 clk = ~clk;

  adpll_lock_ctrl dut (
    .fpga_clk_i   (clk),
    .reset_n_i    (rst_n),
    .ref_clk_i    (ref_clk),
    .start_i      (start),
    .error_i      (err),
    .dco_cc_i     (dco),
    .pll_reset_o  (pll_reset),
    .pll_enable_o (pll_enable),
    .gain_sel_o   (gain_sel),
    .locked_o     (locked),
    .loss_o       (loss),
    .fail_o       (fail),
    .rail_o       (rail),
    .retry_count_o(retry_count),
    .state_o      (state)
  );

  int checks = 0;
  int passed = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // ---------------- behavioural model ----------------
  bit hist[$];
  int ref_phase = 0;
  int consumed = 0;
  int m_st, m_retry, m_cnt, m_cyc, m_ticks, m_to, m_rail_cnt;
  bit m_loss, m_railp;
  int exp_rst [7] = '{1, 1, 0, 0, 0, 0, 1};
  int exp_en  [7] = '{0, 0, 1, 1, 1, 1, 0};
  int exp_gain[7] = '{0, 0, 2, 2, 1, 1, 0};

  task automatic model_reset();
    m_st = S_IDLE; m_retry = 0; m_cnt = 0; m_cyc = 0; m_ticks = 0;
    m_to = 0; m_rail_cnt = 0; m_loss = 0; m_railp = 0;
    hist.delete();
    for (int i = 0; i < 8; i++) hist.push_back(1'b0);
  endtask

  // A reference rise sampled at edge n-3 (with a low at n-4) is acted on at edge n.
  function automatic bit next_tick();
    return hist[hist.size()-3] && !hist[hist.size()-4];
  endfunction

  task automatic model_edge(input bit tk);
    int prev, mag;
    bit fire, do_abort;
    prev = m_st; m_loss = 0; m_railp = 0; fire = 0; do_abort = 0;
    mag = int'($signed(err));
    if (mag < 0) mag = -mag;
`ifdef ADPLL_DCO_RAIL_CHECK_EN
    if (tk && (m_st == S_COARSE || m_st == S_FINE || m_st == S_LOCKED)) begin
      if (dco == 9'h0FF || dco == 9'h100) m_rail_cnt++;
      else m_rail_cnt = 0;
      fire = (m_rail_cnt >= 8);
    end
`endif
    if (!start) m_st = S_IDLE;
    else begin
      case (m_st)
        S_IDLE: begin m_retry = 1; m_st = S_RST; end
        S_RST: begin
          m_cyc++;
          if (m_cyc == 8) begin m_st = S_SETTLE; m_to = 0; end
        end
        S_SETTLE: if (tk) begin
          m_ticks++;
          if (m_ticks == 32) m_st = S_COARSE;
        end
        S_COARSE: if (tk) begin
          m_to++;
          if (mag <= 16) m_cnt++; else m_cnt = 0;
          if (m_cnt == 8) m_st = S_FINE;
          else do_abort = (m_to >= 1024) || fire;
        end
        S_FINE: if (tk) begin
          m_to++;
          if (mag > 16) m_st = S_COARSE;
          else begin
            if (mag <= 4) m_cnt++; else m_cnt = 0;
            if (m_cnt == 16) m_st = S_LOCKED;
          end
          if (m_st == S_FINE) do_abort = (m_to >= 1024) || fire;
        end
        S_LOCKED: if (tk) begin
          if (mag > 16) m_cnt++; else m_cnt = 0;
          if (m_cnt == 4) begin m_st = S_COARSE; m_loss = 1; m_to = 0; end
          else do_abort = fire;
        end
        default: ;
      endcase
      if (do_abort) begin
        m_railp = fire;
        if (m_retry < 3) begin m_retry++; m_st = S_RST; end
        else m_st = S_FAILED;
      end
    end
    if (m_st != prev) begin m_cnt = 0; m_cyc = 0; m_ticks = 0; m_rail_cnt = 0; end
  endtask

  task automatic step();
    bit r, tk;
    logic [12:0] act, exp;
    r  = ref_clk;
    tk = next_tick();
    @(posedge clk);
    hist.push_back(rst_n ? r : 1'b0);
    if (hist.size() > 16) void'(hist.pop_front());
    if (rst_n) begin
      model_edge(tk);
      if (tk) consumed++;
    end
    #1;
    act = {state, pll_reset, pll_enable, gain_sel, locked, loss, fail, rail, retry_count};
    exp = {3'(m_st), 1'(exp_rst[m_st]), 1'(exp_en[m_st]), 2'(exp_gain[m_st]),
           1'(m_st == S_LOCKED), m_loss, 1'(m_st == S_FAILED), m_railp, 2'(m_retry)};
    check("cycle", int'(act), int'(exp));
    ref_phase++;
    ref_clk = ((ref_phase % REF_DIV) < (REF_DIV / 2));
  endtask

  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic run_ticks(input int n);
    int target, budget;
    target = consumed + n;
    budget = n * REF_DIV + 2 * REF_DIV;
    while (consumed < target && budget > 0) begin step(); budget--; end
    if (consumed < target) check("tick_budget", consumed, target);
  endtask

  typedef struct {
    bit         start;
    logic [7:0] err;
    bit         by_tick;
    int         n;
    int         st;
    int         lk;
    int         loss;
    int         retry;
    string      name;
  } vec_t;
  vec_t vecs[$];

  task automatic add_vec(input bit s, input logic [7:0] e, input bit bt, input int n,
                         input int st, input int lk, input int ls, input int rc,
                         input string nm);
    vec_t v;
    v.start = s; v.err = e; v.by_tick = bt; v.n = n; v.st = st;
    v.lk = lk; v.loss = ls; v.retry = rc; v.name = nm;
    vecs.push_back(v);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int attempts, to_ticks, prev_st, budget;
    bit stopped;

    model_reset();
    run_cycles(3);
    check("rst_state", int'(state), S_IDLE);
    check("rst_pll_reset", int'(pll_reset), 1);
    check("rst_enable", int'(pll_enable), 0);
    check("rst_gain", int'(gain_sel), 0);
    check("rst_retry", int'(retry_count), 0);
    rst_n = 1'b1;
    run_cycles(2);

    // nominal acquisition, lock, and loss of lock
    add_vec(1, 8'd0,  0, 1,  S_RST,    0, 0, 1, "enter_reset");
    add_vec(1, 8'd0,  0, 7,  S_RST,    0, 0, 1, "reset_hold");
    add_vec(1, 8'd0,  0, 1,  S_SETTLE, 0, 0, 1, "enter_settle");
    add_vec(1, 8'd0,  1, 31, S_SETTLE, 0, 0, 1, "settle_hold");
    add_vec(1, 8'd0,  1, 1,  S_COARSE, 0, 0, 1, "enter_coarse");
    add_vec(1, 8'd0,  1, 7,  S_COARSE, 0, 0, 1, "coarse_hold");
    add_vec(1, 8'd0,  1, 1,  S_FINE,   0, 0, 1, "enter_fine");
    add_vec(1, 8'd0,  1, 15, S_FINE,   0, 0, 1, "fine_hold");
    add_vec(1, 8'd0,  1, 1,  S_LOCKED, 1, 0, 1, "enter_locked");
    add_vec(1, 8'd20, 1, 3,  S_LOCKED, 1, 0, 1, "three_bad");
    add_vec(1, 8'd0,  1, 1,  S_LOCKED, 1, 0, 1, "good_clears");
    add_vec(1, 8'd20, 1, 3,  S_LOCKED, 1, 0, 1, "three_bad_again");
    add_vec(1, 8'd20, 1, 1,  S_COARSE, 0, 1, 1, "loss");
    add_vec(1, 8'd0,  0, 1,  S_COARSE, 0, 0, 1, "loss_one_cycle");

    foreach (vecs[i]) begin
      start = vecs[i].start;
      err   = vecs[i].err;
      if (vecs[i].by_tick) run_ticks(vecs[i].n);
      else                 run_cycles(vecs[i].n);
      check({vecs[i].name, "_state"}, int'(state), vecs[i].st);
      check({vecs[i].name, "_locked"}, int'(locked), vecs[i].lk);
      check({vecs[i].name, "_loss"}, int'(loss), vecs[i].loss);
      check({vecs[i].name, "_retry"}, int'(retry_count), vecs[i].retry);
    end

    // FINE with alternating 3/5 never locks; 17 drops back to COARSE
    err = 8'd0;
    run_ticks(8);
    check("alt_enter_fine", int'(state), S_FINE);
    for (int k = 0; k < 40; k++) begin
      err = (k % 2 == 0) ? 8'd3 : 8'd5;
      run_ticks(1);
    end
    check("alt_state", int'(state), S_FINE);
    check("alt_locked", int'(locked), 0);
    err = 8'd17;
    run_ticks(1);
    check("fine_to_coarse", int'(state), S_COARSE);

    // start drops on the very tick that would complete lock
    err = 8'd0;
    run_ticks(8);
    run_ticks(15);
    check("pre_abort_fine", int'(state), S_FINE);
    stopped = 0;
    for (int k = 0; k < 2 * REF_DIV && !stopped; k++) begin
      if (next_tick()) begin start = 1'b0; stopped = 1; end
      step();
    end
    check("abort_state", int'(state), S_IDLE);
    check("abort_locked", int'(locked), 0);
    check("abort_pll_reset", int'(pll_reset), 1);

    // persistent -128 error: three timed-out attempts, then FAILED
    start = 1'b1;
    err = 8'h80;
    attempts = 0; to_ticks = 0; budget = 25000;
    while (!fail && budget > 0) begin
      prev_st = int'(state);
      if (next_tick() && (prev_st == S_COARSE || prev_st == S_FINE)) to_ticks++;
      step();
      budget--;
      if (int'(state) == S_RST && prev_st != S_RST) attempts++;
      if ((prev_st == S_COARSE || prev_st == S_FINE) &&
          (int'(state) == S_RST || int'(state) == S_FAILED)) begin
        check("timeout_ticks", to_ticks, 1024);
        to_ticks = 0;
      end
    end
    check("fail_reached", int'(fail), 1);
    check("fail_attempts", attempts, 3);
    check("fail_retry", int'(retry_count), 3);
    check("fail_state", int'(state), S_FAILED);
    start = 1'b0;
    step();
    check("fail_exit_state", int'(state), S_IDLE);
    check("fail_exit_flag", int'(fail), 0);

    // DCO pinned on the upper rail while COARSE
    start = 1'b1;
    err = 8'd100;
    run_cycles(9);
    run_ticks(32);
    check("rail_pre_coarse", int'(state), S_COARSE);
    dco = 9'h0FF;
    run_ticks(7);
    check("rail_seven", int'(state), S_COARSE);
    run_ticks(1);
`ifdef ADPLL_DCO_RAIL_CHECK_EN
    check("rail_pulse", int'(rail), 1);
    check("rail_state", int'(state), S_RST);
    check("rail_retry", int'(retry_count), 2);
`else
    check("rail_pulse", int'(rail), 0);
    check("rail_state", int'(state), S_COARSE);
    check("rail_retry", int'(retry_count), 1);
`endif
    dco = 9'd0;
    run_cycles(5);

    // asynchronous reset in the middle of an attempt
    rst_n = 1'b0;
    #1;
    check("arst_state", int'(state), S_IDLE);
    check("arst_pll_reset", int'(pll_reset), 1);
    check("arst_retry", int'(retry_count), 0);
    model_reset();
    run_cycles(2);
    rst_n = 1'b1;

    // randomized regimes compared cycle by cycle against the model
    for (int blk = 0; blk < 30; blk++) begin
      int regime;
      bit railish;
      regime  = (($urandom_range(0, 1)) == 0) ? 0 : int'($urandom_range(1, 3));
      railish = ($urandom_range(0, 3) == 0);
      for (int k = 0; k < 600; k++) begin
        int v;
        start = ($urandom_range(0, 1999) != 0);
        case (regime)
          0:       v = int'($urandom_range(0, 6)) - 3;
          1:       v = int'($urandom_range(0, 34)) - 17;
          2:       v = int'($urandom_range(0, 255));
          default: v = ($urandom_range(0, 1) == 0) ? -128 : 127;
        endcase
        err = 8'(v);
        if (railish && $urandom_range(0, 9) != 0)
          dco = ($urandom_range(0, 1) == 0) ? 9'h0FF : 9'h100;
        else
          dco = 9'($urandom_range(0, 511));
        step();
      end
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
